mem_sequencer: RTL and testbench

MEM_SEQUENCER -- requirements
Module: mem_sequencer

---
 rtl/mem_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_mem_sequencer.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_sequencer.sv
// Instruction fetch / data-access sequencer between a CPU core and a word memory.
// Optional retired-instruction counter enabled by defining MEM_SEQUENCER_RETIRE_CNT_EN.
module mem_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        sys_clk,
  input  logic        sys_reset,
  input  logic        run,
  input  logic [31:0] progctr,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        memload_flag,
  input  logic        memstore_flag,
  output logic [31:0] instruction,
  output logic [31:0] from_memory,
  output logic        cpu_step,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        busy,
  output logic        fault,
  output logic [31:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_DATA,
    S_COMMIT,
    S_FAULT
  } state_t;

  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

  state_t      state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic [7:0]  wait_inc;
  logic [31:0] instr_q, instr_d;
  logic [31:0] from_mem_q, from_mem_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [31:0] fetch_addr;
  logic        unused_progctr_bits;

  assign fetch_addr          = {progctr[31:2], 2'b00};
  assign unused_progctr_bits = ^progctr[1:0];
  assign wait_inc            = wait_q + 8'd1;

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    instr_d    = instr_q;
    from_mem_d = from_mem_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;

    case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d = S_FETCH;
          addr_d  = fetch_addr;
          we_d    = 1'b0;
          wdata_d = 32'd0;
          wait_d  = 8'd0;
        end
      end

      S_FETCH: begin
        if (mem_ready) begin
          instr_d = mem_rdata;
          state_d = S_DECODE;
        end else begin
          wait_d = wait_inc;
          if (wait_inc == TIMEOUT_LIMIT) begin
            state_d = S_FAULT;
          end
        end
      end

      S_DECODE: begin
        if (memload_flag && memstore_flag) begin
          state_d = S_FAULT;
        end else if (memload_flag || memstore_flag) begin
          state_d = S_DATA;
          addr_d  = cpu_addr;
          we_d    = memstore_flag;
          wdata_d = memstore_flag ? cpu_wdata : 32'd0;
          wait_d  = 8'd0;
        end else begin
          state_d = S_COMMIT;
        end
      end

      S_DATA: begin
        if (mem_ready) begin
          if (!we_q) begin
            from_mem_d = mem_rdata;
          end
          we_d    = 1'b0;
          wdata_d = 32'd0;
          state_d = S_COMMIT;
        end else begin
          wait_d = wait_inc;
          if (wait_inc == TIMEOUT_LIMIT) begin
            state_d = S_FAULT;
          end
        end
      end

      S_COMMIT: begin
        // run is only sampled here, so dropping it mid-instruction never aborts
        if (run) begin
          state_d = S_FETCH;
          addr_d  = fetch_addr;
          we_d    = 1'b0;
          wdata_d = 32'd0;
          wait_d  = 8'd0;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_FAULT: begin
        state_d = S_FAULT;
      end

      default: begin
        state_d = S_FAULT;
      end
    endcase

    if (state_d == S_FAULT) begin
      we_d    = 1'b0;
      wdata_d = 32'd0;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      state_q    <= S_IDLE;
      wait_q     <= 8'd0;
      instr_q    <= 32'd0;
      from_mem_q <= 32'd0;
      addr_q     <= 32'd0;
      we_q       <= 1'b0;
      wdata_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      instr_q    <= instr_d;
      from_mem_q <= from_mem_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
    end
  end

  // Handshake outputs decode straight from the state so reset drops them at once
  assign mem_req     = (state_q == S_FETCH) || (state_q == S_DATA);
  assign cpu_step    = (state_q == S_COMMIT);
  assign fault       = (state_q == S_FAULT);
  assign busy        = (state_q != S_IDLE) && (state_q != S_FAULT);
  assign mem_we      = we_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign instruction = instr_q;
  assign from_memory = from_mem_q;

`ifdef MEM_SEQUENCER_RETIRE_CNT_EN
  logic [31:0] retired_q, retired_d;

  always_comb begin
    retired_d = retired_q;
    if (state_q == S_COMMIT) begin
      retired_d = retired_q + 32'd1;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      retired_q <= 32'd0;
    end else begin
      retired_q <= retired_d;
    end
  end

  assign retired = retired_q;
`else
  assign retired = 32'd0;
`endif

endmodule

// File: tb/tb_mem_sequencer.sv
// Scoreboard bench for mem_sequencer: a queued memory model feeds responses,
// expected accesses and commits are queued at stimulus time and checked as they appear.
module tb_mem_sequencer;

  logic        sys_clk;
  logic        sys_reset;
  logic        run;
  logic [31:0] progctr;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        memload_flag;
  logic        memstore_flag;
  logic [31:0] instruction;
  logic [31:0] from_memory;
  logic        cpu_step;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        busy;
  logic        fault;
  logic [31:0] retired;

  mem_sequencer #(.TIMEOUT_CYCLES(16)) dut (
    .sys_clk      (sys_clk),
    .sys_reset    (sys_reset),
    .run          (run),
    .progctr      (progctr),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .memload_flag (memload_flag),
    .memstore_flag(memstore_flag),
    .instruction  (instruction),
    .from_memory  (from_memory),
    .cpu_step     (cpu_step),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready),
    .busy         (busy),
    .fault        (fault),
    .retired      (retired)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

`ifdef MEM_SEQUENCER_RETIRE_CNT_EN
  localparam bit RET_EN = 1'b1;
`else
  localparam bit RET_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] rdata;
    int          waits;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } acc_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] fmem;
  } exp_t;

  resp_t resp_q[$];
  acc_t  acc_q[$];
  exp_t  exp_q[$];

  int          n_vectors;
  int          n_miscompares;
  logic [31:0] model_fmem;
  int          model_retired;
  logic        force_ready;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory model: each new request pops one response and answers after its wait count
  initial begin
    resp_t r_cur;
    int    r_cnt;
    logic  r_active;
    r_active  = 1'b0;
    r_cnt     = 0;
    r_cur     = '{32'd0, -1};
    mem_ready = 1'b0;
    mem_rdata = 32'hBAD0BAD0;
    forever begin
      @(posedge sys_clk);
      #1;
      if (sys_reset || !mem_req) begin
        r_active  = 1'b0;
        mem_ready = force_ready;
        mem_rdata = 32'hBAD0BAD0;
      end else begin
        if (!r_active) begin
          r_active = 1'b1;
          r_cnt    = 0;
          if (resp_q.size() > 0) r_cur = resp_q.pop_front();
          else r_cur = '{32'd0, -1};
        end
        if (r_cur.waits >= 0 && r_cnt >= r_cur.waits) begin
          mem_ready = 1'b1;
          mem_rdata = r_cur.rdata;
        end else begin
          mem_ready = 1'b0;
          mem_rdata = 32'hBAD0BAD0;
          r_cnt++;
        end
      end
    end
  end

  // Monitor: checks every request cycle against the queued access, and every commit
  initial begin
    acc_t a;
    exp_t e;
    forever begin
      @(negedge sys_clk);
      if (!sys_reset) begin
        if (mem_req) begin
          if (acc_q.size() == 0) begin
            check_val("acc_unexpected", 32'(mem_req), 32'd0);
          end else begin
            a = acc_q[0];
            check_val("mem_addr", mem_addr, a.addr);
            check_val("mem_we", 32'(mem_we), 32'(a.we));
            check_val("mem_wdata", mem_wdata, a.wdata);
            if (mem_ready) void'(acc_q.pop_front());
          end
        end
        if (cpu_step) begin
          model_retired++;
          if (exp_q.size() == 0) begin
            check_val("step_unexpected", 32'(cpu_step), 32'd0);
          end else begin
            e = exp_q.pop_front();
            check_val("instruction", instruction, e.instr);
            check_val("from_memory", from_memory, e.fmem);
          end
        end
      end
    end
  end

  task automatic do_reset();
    sys_reset     = 1'b1;
    run           = 1'b0;
    memload_flag  = 1'b0;
    memstore_flag = 1'b0;
    acc_q.delete();
    resp_q.delete();
    exp_q.delete();
    model_fmem    = 32'd0;
    model_retired = 0;
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    check_val("rst_instruction", instruction, 32'd0);
    check_val("rst_from_memory", from_memory, 32'd0);
    check_val("rst_cpu_step", 32'(cpu_step), 32'd0);
    check_val("rst_mem_req", 32'(mem_req), 32'd0);
    check_val("rst_mem_we", 32'(mem_we), 32'd0);
    check_val("rst_mem_addr", mem_addr, 32'd0);
    check_val("rst_mem_wdata", mem_wdata, 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_fault", 32'(fault), 32'd0);
    check_val("rst_retired", retired, 32'd0);
    sys_reset = 1'b0;
  endtask

  // Issue one instruction and wait for its commit; drop_at>0 lowers run after that many cycles
  task automatic run_instr(input logic [31:0] pc, input logic ld, input logic st,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] iword, input logic [31:0] dword,
                           input int wf, input int wdd, input int drop_at, input string tag);
    int   cyc;
    int   exp_lat;
    logic seen;
    progctr       = pc;
    memload_flag  = ld;
    memstore_flag = st;
    cpu_addr      = addr;
    cpu_wdata     = wd;
    run           = 1'b1;
    acc_q.push_back('{{pc[31:2], 2'b00}, 1'b0, 32'd0});
    resp_q.push_back('{iword, wf});
    exp_lat = 3 + wf;
    if (ld || st) begin
      acc_q.push_back('{addr, st, st ? wd : 32'd0});
      resp_q.push_back('{dword, wdd});
      exp_lat = exp_lat + 1 + wdd;
      if (ld) model_fmem = dword;
    end
    exp_q.push_back('{iword, model_fmem});
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 200) begin
      @(posedge sys_clk);
      cyc++;
      @(negedge sys_clk);
      if (cyc == drop_at) run = 1'b0;
      if (cpu_step) seen = 1'b1;
    end
    check_val({tag, "_step_seen"}, 32'(seen), 32'd1);
    check_val({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
    $display("txn %s pc=%h ld=%0d st=%0d latency=%0d instr=%h from_mem=%h",
             tag, pc, ld, st, cyc, instruction, from_memory);
    if (drop_at > 0) begin
      @(posedge sys_clk);
      @(negedge sys_clk);
      check_val({tag, "_idle_busy"}, 32'(busy), 32'd0);
      check_val({tag, "_idle_step"}, 32'(cpu_step), 32'd0);
    end
  endtask

  // Run until fault rises; reports the cycle it was seen and whether a commit sneaked in
  task automatic wait_fault(input int exp_cyc, input string tag);
    int   cyc;
    logic stepped;
    cyc     = 0;
    stepped = 1'b0;
    while (!fault && cyc < 100) begin
      @(posedge sys_clk);
      cyc++;
      @(negedge sys_clk);
      if (cpu_step) stepped = 1'b1;
    end
    check_val({tag, "_fault_cycles"}, 32'(cyc), 32'(exp_cyc));
    check_val({tag, "_no_step"}, 32'(stepped), 32'd0);
    run = 1'b0;
    repeat (4) begin
      @(posedge sys_clk);
      @(negedge sys_clk);
      check_val({tag, "_fault_hold"}, 32'(fault), 32'd1);
      check_val({tag, "_fault_req"}, 32'(mem_req), 32'd0);
      check_val({tag, "_fault_busy"}, 32'(busy), 32'd0);
    end
    $display("txn %s fault after %0d cycles", tag, cyc);
  endtask

  initial begin
    n_vectors     = 0;
    n_miscompares = 0;
    force_ready   = 1'b0;
    progctr       = 32'd0;
    cpu_addr      = 32'd0;
    cpu_wdata     = 32'd0;
    model_fmem    = 32'd0;
    model_retired = 0;
    do_reset();

    force_ready = 1'b1;
    repeat (3) begin
      @(posedge sys_clk);
      @(negedge sys_clk);
      check_val("idle_busy", 32'(busy), 32'd0);
      check_val("idle_req", 32'(mem_req), 32'd0);
      check_val("idle_instr", instruction, 32'd0);
    end
    force_ready = 1'b0;
    $display("txn idle_spurious_ready done");

    run_instr(32'h8, 1'b0, 1'b0, 32'h0, 32'h0, 32'h00500093, 32'h0, 0, 0, 1, "fetch0");
    run_instr(32'h10, 1'b1, 1'b0, 32'h100, 32'h12345678, 32'h10002083, 32'hEAD, 0, 2, 0, "load");
    run_instr(32'h14, 1'b0, 1'b1, 32'h104, 32'hCAFE, 32'h00A12223, 32'h0, 0, 3, 0, "store");
    run_instr(32'h1B, 1'b0, 1'b0, 32'h0, 32'h0, 32'h00108113, 32'h0, 2, 0, 0, "fwait");
    run_instr(32'h20, 1'b1, 1'b0, 32'h203, 32'h0, 32'h000000AB, 32'hBEEF, 1, 3, 4, "drop_data");
    check_val("retired_5", retired, RET_EN ? 32'(model_retired) : 32'd0);
    $display("txn retired=%0d model=%0d", retired, model_retired);

    force_ready = 1'b1;
    run_instr(32'h30, 1'b0, 1'b0, 32'h0, 32'h0, 32'h00000013, 32'h0, 2, 0, 1, "spur");
    force_ready = 1'b0;

    progctr       = 32'h40;
    memload_flag  = 1'b1;
    memstore_flag = 1'b1;
    run           = 1'b1;
    acc_q.push_back('{32'h40, 1'b0, 32'd0});
    resp_q.push_back('{32'h00000033, 0});
    wait_fault(3, "both_flags");
    do_reset();

    progctr = 32'h50;
    run     = 1'b1;
    acc_q.push_back('{32'h50, 1'b0, 32'd0});
    resp_q.push_back('{32'd0, -1});
    wait_fault(17, "timeout");
    do_reset();

    progctr = 32'h60;
    run     = 1'b1;
    acc_q.push_back('{32'h60, 1'b0, 32'd0});
    resp_q.push_back('{32'h11, 20});
    repeat (3) @(posedge sys_clk);
    #2;
    check_val("midreq_req_before", 32'(mem_req), 32'd1);
    sys_reset = 1'b1;
    #1;
    check_val("midreq_req_async", 32'(mem_req), 32'd0);
    check_val("midreq_busy_async", 32'(busy), 32'd0);
    $display("txn midreq_reset mem_req=%0d", mem_req);
    do_reset();
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    check_val("final_retired", retired, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
